instr_decode_stage: RTL and testbench
=====================================

Name: instr_decode_stage

Overview:
- Pipelined, parametrised successor to the combinational instruction decoder.
- Decodes RV32I/RV64I base opcodes (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP), flags illegal encodings, and enqueues the decoded bundle into a DEPTH-entry queue.
- Sits between fetch and the register-read/execute stage, with valid/ready handshakes on both sides and a flush input for redirects.

Parameters:
XLEN, 32, data/immediate/PC width; legal values 32 or 64
DEPTH, 2, decoded-bundle queue entries; legal values 1..8
CNT_W, $clog2(DEPTH+1), width of the occupancy count

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  drop all queued entries and any same-cycle input
in_valid  in  1  fetch presents an instruction
in_ready  out  1  stage can accept an instruction
in_instr  in  32  raw instruction word
in_pc  in  XLEN  PC of in_instr
out_valid  out  1  head entry is valid
out_ready  in  1  consumer accepts the head entry
out_pc  out  XLEN  PC of the head entry
out_op_class  out  4  decoded class (see Behaviour)
out_rd_idx  out  5  destination register index
out_rs1_idx  out  5  source register 1 index
out_rs2_idx  out  5  source register 2 index
out_imm  out  XLEN  sign-extended immediate
out_funct3  out  3  instr[14:12]
out_funct7b5  out  1  instr[30]
out_rd_we  out  1  writes rd
out_illegal  out  1  illegal-instruction flag
count  out  CNT_W  queue occupancy

Behaviour:
- Reset (async, rst_n=0): count=0, pointers=0, out_valid=0, in_ready=0. All bundle outputs read 0 while out_valid=0. After rst_n deasserts, in_ready rises on the first clk edge.
- Handshakes:
  - Push when in_valid&&in_ready; pop when out_valid&&out_ready.
  - in_ready = (count<DEPTH) && !flush. It is registered-count based, with no combinational path from out_ready.
  - Push and pop in the same cycle are allowed whenever in_ready=1; count is then unchanged.
- Latency: the instruction is visible on out_* in the cycle after its push (1 cycle). No pass-through bypass.
- Queue: circular buffer with wrap-around at DEPTH-1 → 0. Order is strictly FIFO. Head outputs are held stable while out_valid&&!out_ready.
- Flush (synchronous, highest priority after reset): next cycle count=0 and out_valid=0. A same-cycle push and pop are both ignored.
- Decode is combinational on in_instr and the result is written at push.
- op_class encoding: 0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BRANCH, 5 LOAD, 6 STORE, 7 OP_IMM, 8 OP, 15 ILLEGAL.
- Immediates, sign-extended from the top instruction bit to XLEN:
  - U: {instr[31:12],12'b0}
  - J: {instr[31],instr[19:12],instr[20],instr[30:21],0}
  - I: instr[31:20]
  - S: {instr[31:25],instr[11:7]}
  - B: {instr[31],instr[7],instr[30:25],instr[11:8],0}
  - OP has imm=0.
- Register indices:
  - rs1 is used by JALR, BRANCH, LOAD, STORE, OP_IMM, OP.
  - rs2 is used by BRANCH, STORE, OP.
  - rd is used by LUI, AUIPC, JAL, JALR, LOAD, OP_IMM, OP.
  - Unused indices are 0.
- rd_we = class writes rd && rd_idx!=0.
- Illegal when any of the following holds:
  - instr[1:0]!=2'b11, or the opcode is not listed.
  - JALR with funct3!=0.
  - BRANCH with funct3 of 2 or 3.
  - LOAD with funct3=7, or funct3 of 3 or 6 when XLEN=32.
  - STORE with funct3>2 (>3 when XLEN=64).
  - OP with funct7 not 0x00/0x20, or 0x20 with funct3 not 0/5.
  - OP_IMM shifts (funct3 1/5) with an invalid funct7: instr[31:25] not 0x00/0x20 for XLEN=32, or instr[31:26] not 0x00/0x10 for XLEN=64, and 0x20/0x10 legal only with funct3=5.
- Illegal entries are still enqueued, in order: op_class=15, illegal=1, indices=0, imm=0, rd_we=0, pc preserved.
- Reset mid-operation: all entries are discarded immediately. Contents are not preserved.

Test Plan:
- LUI 0x123450B7, pc 0x100 → next cycle out_valid=1, class 0, rd=1, imm=0x12345000, rd_we=1, rs1=rs2=0, pc 0x100.
- JAL 0xFFDFF0EF → class 2, rd=1, imm=0xFFFFFFFC; ADDI 0xFFF00293 → class 7, rd=5, rs1=0, imm=0xFFFFFFFF.
- BEQ 0x00208863 → class 4, rs1=1, rs2=2, imm=16, rd=0, rd_we=0. Word 0x00000000 → class 15, illegal=1.
- DEPTH=2, out_ready=0, push A, B, C back-to-back → in_ready=0 after 2 pushes, count=2, C held. With out_ready=1 → A, B, C emerge in order, each held stable while stalled.
- Queue full, then assert flush with in_valid=1 → next cycle count=0, out_valid=0, flushed input never appears. Continuous push+pop at count=1 → count stays 1 across pointer wrap.
- Assert rst_n=0 asynchronously mid-stream with count=2 → out_valid and count drop to 0 without a clock edge. After release, the first new push emerges correctly.

Source files
------------

// File: rtl/instr_decode_stage.sv
// Instruction decode stage for RV32I/RV64I base opcodes.
// Each accepted instruction is decoded and written into a DEPTH-entry
// circular queue. The queue head drives the out_* bundle one cycle after
// the push; there is no bypass path from the input to the output.
module instr_decode_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [3:0]       out_op_class,
  output logic [4:0]       out_rd_idx,
  output logic [4:0]       out_rs1_idx,
  output logic [4:0]       out_rs2_idx,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_funct3,
  output logic             out_funct7b5,
  output logic             out_rd_we,
  output logic             out_illegal,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [3:0] CLS_LUI    = 4'd0;
  localparam logic [3:0] CLS_AUIPC  = 4'd1;
  localparam logic [3:0] CLS_JAL    = 4'd2;
  localparam logic [3:0] CLS_JALR   = 4'd3;
  localparam logic [3:0] CLS_BRANCH = 4'd4;
  localparam logic [3:0] CLS_LOAD   = 4'd5;
  localparam logic [3:0] CLS_STORE  = 4'd6;
  localparam logic [3:0] CLS_OP_IMM = 4'd7;
  localparam logic [3:0] CLS_OP     = 4'd8;
  localparam logic [3:0] CLS_ILL    = 4'd15;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [3:0]      op_class;
    logic [4:0]      rd_idx;
    logic [4:0]      rs1_idx;
    logic [4:0]      rs2_idx;
    logic [XLEN-1:0] imm;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic            rd_we;
    logic            illegal;
  } bundle_t;

  // Advance a queue pointer, wrapping from DEPTH-1 back to 0.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Decode intermediates
  logic [6:0]  opcode_s;
  logic [2:0]  f3_s;
  logic [6:0]  f7_s;
  logic [3:0]  cls_s;
  logic        ill_s;
  logic        use_rd_s;
  logic        use_rs1_s;
  logic        use_rs2_s;
  logic        shift_ok_s;
  logic [31:0] imm32_s;
  logic [4:0]  rd_s;
  bundle_t     dec_s;

  // Queue state
  bundle_t          mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             ready_en_r;
  logic             in_ready_s;
  logic             out_valid_s;
  logic             push_s;
  logic             pop_s;
  bundle_t          head_s;

  assign opcode_s = in_instr[6:0];
  assign f3_s     = in_instr[14:12];
  assign f7_s     = in_instr[31:25];

  // Legality of an OP-IMM shift encoding; the arithmetic-shift form is only valid for funct3=5.
  always_comb begin
    shift_ok_s = 1'b0;
    if (XLEN == 64) begin
      shift_ok_s = (in_instr[31:26] == 6'h00) ||
                   ((in_instr[31:26] == 6'h10) && (f3_s == 3'd5));
    end else begin
      shift_ok_s = (f7_s == 7'h00) ||
                   ((f7_s == 7'h20) && (f3_s == 3'd5));
    end
  end

  // Classify the opcode, pick the immediate format and flag illegal encodings.
  always_comb begin
    cls_s     = CLS_ILL;
    ill_s     = 1'b0;
    use_rd_s  = 1'b0;
    use_rs1_s = 1'b0;
    use_rs2_s = 1'b0;
    imm32_s   = 32'd0;
    case (opcode_s)
      OPC_LUI: begin
        cls_s    = CLS_LUI;
        use_rd_s = 1'b1;
        imm32_s  = {in_instr[31:12], 12'd0};
      end
      OPC_AUIPC: begin
        cls_s    = CLS_AUIPC;
        use_rd_s = 1'b1;
        imm32_s  = {in_instr[31:12], 12'd0};
      end
      OPC_JAL: begin
        cls_s    = CLS_JAL;
        use_rd_s = 1'b1;
        imm32_s  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                    in_instr[20], in_instr[30:21], 1'b0};
      end
      OPC_JALR: begin
        cls_s     = CLS_JALR;
        use_rd_s  = 1'b1;
        use_rs1_s = 1'b1;
        imm32_s   = {{20{in_instr[31]}}, in_instr[31:20]};
        ill_s     = (f3_s != 3'd0);
      end
      OPC_BRANCH: begin
        cls_s     = CLS_BRANCH;
        use_rs1_s = 1'b1;
        use_rs2_s = 1'b1;
        imm32_s   = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                     in_instr[30:25], in_instr[11:8], 1'b0};
        ill_s     = (f3_s == 3'd2) || (f3_s == 3'd3);
      end
      OPC_LOAD: begin
        cls_s     = CLS_LOAD;
        use_rd_s  = 1'b1;
        use_rs1_s = 1'b1;
        imm32_s   = {{20{in_instr[31]}}, in_instr[31:20]};
        ill_s     = (f3_s == 3'd7) ||
                    ((XLEN == 32) && ((f3_s == 3'd3) || (f3_s == 3'd6)));
      end
      OPC_STORE: begin
        cls_s     = CLS_STORE;
        use_rs1_s = 1'b1;
        use_rs2_s = 1'b1;
        imm32_s   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        ill_s     = (XLEN == 64) ? (f3_s > 3'd3) : (f3_s > 3'd2);
      end
      OPC_OP_IMM: begin
        cls_s     = CLS_OP_IMM;
        use_rd_s  = 1'b1;
        use_rs1_s = 1'b1;
        imm32_s   = {{20{in_instr[31]}}, in_instr[31:20]};
        ill_s     = ((f3_s == 3'd1) || (f3_s == 3'd5)) && !shift_ok_s;
      end
      OPC_OP: begin
        cls_s     = CLS_OP;
        use_rd_s  = 1'b1;
        use_rs1_s = 1'b1;
        use_rs2_s = 1'b1;
        imm32_s   = 32'd0;
        ill_s     = !((f7_s == 7'h00) ||
                      ((f7_s == 7'h20) && ((f3_s == 3'd0) || (f3_s == 3'd5))));
      end
      default: begin
        cls_s = CLS_ILL;
        ill_s = 1'b1;
      end
    endcase
    // Compressed/reserved encodings never reach the base decoder.
    ill_s = ill_s | (in_instr[1:0] != 2'b11);
  end

  assign rd_s = use_rd_s ? in_instr[11:7] : 5'd0;

  // Assemble the bundle written at push; illegal words keep only pc and raw funct bits.
  always_comb begin
    dec_s          = '0;
    dec_s.pc       = in_pc;
    dec_s.funct3   = f3_s;
    dec_s.funct7b5 = in_instr[30];
    if (ill_s) begin
      dec_s.op_class = CLS_ILL;
      dec_s.illegal  = 1'b1;
    end else begin
      dec_s.op_class = cls_s;
      dec_s.illegal  = 1'b0;
      dec_s.rd_idx   = rd_s;
      dec_s.rs1_idx  = use_rs1_s ? in_instr[19:15] : 5'd0;
      dec_s.rs2_idx  = use_rs2_s ? in_instr[24:20] : 5'd0;
      dec_s.imm      = XLEN'($signed(imm32_s));
      dec_s.rd_we    = use_rd_s && (rd_s != 5'd0);
    end
  end

  assign out_valid_s = (count_r != {CNT_W{1'b0}});
  assign in_ready_s  = ready_en_r && (count_r < CNT_W'(DEPTH)) && !flush;
  assign push_s      = in_valid && in_ready_s;
  assign pop_s       = out_valid_s && out_ready && !flush;

  // Hold in_ready low until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_r <= 1'b0;
    end else begin
      ready_en_r <= 1'b1;
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Write the decoded bundle into the slot at the write pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= dec_s;
    end
  end

  // Head entry, forced to zero whenever the queue is empty.
  always_comb begin
    head_s = '0;
    if (out_valid_s) begin
      head_s = mem_r[rd_ptr_r];
    end else begin
      head_s = '0;
    end
  end

  assign in_ready     = in_ready_s;
  assign out_valid    = out_valid_s;
  assign count        = count_r;
  assign out_pc       = head_s.pc;
  assign out_op_class = head_s.op_class;
  assign out_rd_idx   = head_s.rd_idx;
  assign out_rs1_idx  = head_s.rs1_idx;
  assign out_rs2_idx  = head_s.rs2_idx;
  assign out_imm      = head_s.imm;
  assign out_funct3   = head_s.funct3;
  assign out_funct7b5 = head_s.funct7b5;
  assign out_rd_we    = head_s.rd_we;
  assign out_illegal  = head_s.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Scoreboard bench for instr_decode_stage (XLEN=32, DEPTH=2).
// Stimulus pushes hand-computed expected bundles into a queue on every
// accepted push; an independent monitor compares the head on each cycle
// the DUT presents out_valid and retires entries on pop.
module tb_instr_decode_stage;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [XLEN-1:0]  in_pc;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_pc;
  logic [3:0]       out_op_class;
  logic [4:0]       out_rd_idx;
  logic [4:0]       out_rs1_idx;
  logic [4:0]       out_rs2_idx;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_funct3;
  logic             out_funct7b5;
  logic             out_rd_we;
  logic             out_illegal;
  logic [CNT_W-1:0] count;

  always #5 clk = ~clk;

  instr_decode_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_op_class(out_op_class), .out_rd_idx(out_rd_idx),
    .out_rs1_idx(out_rs1_idx), .out_rs2_idx(out_rs2_idx), .out_imm(out_imm),
    .out_funct3(out_funct3), .out_funct7b5(out_funct7b5),
    .out_rd_we(out_rd_we), .out_illegal(out_illegal), .count(count)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [3:0]  cls;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic        f7;
    logic        we;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  exp_t vt[12];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] instr, input logic [31:0] pc,
                              input logic [3:0] cls, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [31:0] imm, input logic [2:0] f3,
                              input logic f7, input logic we, input logic ill);
    exp_t e;
    e.instr = instr; e.pc = pc; e.cls = cls; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
    e.imm = imm; e.f3 = f3; e.f7 = f7; e.we = we; e.ill = ill;
    return e;
  endfunction

  // Monitor: compare the presented head against the scoreboard front; retire on pop.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && !flush) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_out: actual pc=%0h class=%0d, required no output", out_pc, out_op_class);
      end else begin
        e = exp_q[0];
        chk("pc",      64'(out_pc),       64'(e.pc));
        chk("class",   64'(out_op_class), 64'(e.cls));
        chk("rd",      64'(out_rd_idx),   64'(e.rd));
        chk("rs1",     64'(out_rs1_idx),  64'(e.rs1));
        chk("rs2",     64'(out_rs2_idx),  64'(e.rs2));
        chk("imm",     64'(out_imm),      64'(e.imm));
        chk("funct3",  64'(out_funct3),   64'(e.f3));
        chk("funct7b5",64'(out_funct7b5), 64'(e.f7));
        chk("rd_we",   64'(out_rd_we),    64'(e.we));
        chk("illegal", 64'(out_illegal),  64'(e.ill));
        if (out_ready) begin
          e = exp_q.pop_front();
        end
      end
    end
  end

  // Drive one instruction and record its expectation once the DUT accepts it.
  task automatic send(input int i);
    int waits;
    waits    = 0;
    in_valid = 1'b1;
    in_instr = vt[i].instr;
    in_pc    = vt[i].pc;
    @(negedge clk);
    while (!in_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    n_cmp++;
    if (!in_ready) begin
      n_fail++;
      $display("FAIL send_timeout: actual in_ready=0 after %0d cycles, required 1", waits);
    end else begin
      exp_q.push_back(vt[i]);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait for the scoreboard and the DUT queue to empty, bounded.
  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || count != 2'd0) && k < 50) begin
      @(posedge clk);
      k++;
    end
    #1;
    n_cmp++;
    if (k >= 50) begin
      n_fail++;
      $display("FAIL drain_timeout: actual %0d entries left, required 0", exp_q.size());
    end
  endtask

  initial begin
    vt[0]  = mk(32'h123450B7, 32'h100, 4'd0,  5'd1,  5'd0, 5'd0, 32'h12345000, 3'd5, 1'b0, 1'b1, 1'b0);
    vt[1]  = mk(32'hFFDFF0EF, 32'h104, 4'd2,  5'd1,  5'd0, 5'd0, 32'hFFFFFFFC, 3'd7, 1'b1, 1'b1, 1'b0);
    vt[2]  = mk(32'hFFF00293, 32'h108, 4'd7,  5'd5,  5'd0, 5'd0, 32'hFFFFFFFF, 3'd0, 1'b1, 1'b1, 1'b0);
    vt[3]  = mk(32'h00208863, 32'h10C, 4'd4,  5'd0,  5'd1, 5'd2, 32'h00000010, 3'd0, 1'b0, 1'b0, 1'b0);
    vt[4]  = mk(32'h00000000, 32'h110, 4'd15, 5'd0,  5'd0, 5'd0, 32'h00000000, 3'd0, 1'b0, 1'b0, 1'b1);
    vt[5]  = mk(32'h00512423, 32'h114, 4'd6,  5'd0,  5'd2, 5'd5, 32'h00000008, 3'd2, 1'b0, 1'b0, 1'b0);
    vt[6]  = mk(32'hFFC0A503, 32'h118, 4'd5,  5'd10, 5'd1, 5'd0, 32'hFFFFFFFC, 3'd2, 1'b1, 1'b1, 1'b0);
    vt[7]  = mk(32'h000010E7, 32'h11C, 4'd15, 5'd0,  5'd0, 5'd0, 32'h00000000, 3'd1, 1'b0, 1'b0, 1'b1);
    vt[8]  = mk(32'h402081B3, 32'h120, 4'd8,  5'd3,  5'd1, 5'd2, 32'h00000000, 3'd0, 1'b1, 1'b1, 1'b0);
    vt[9]  = mk(32'h00001017, 32'h124, 4'd1,  5'd0,  5'd0, 5'd0, 32'h00001000, 3'd1, 1'b0, 1'b0, 1'b0);
    vt[10] = mk(32'h40009093, 32'h128, 4'd15, 5'd0,  5'd0, 5'd0, 32'h00000000, 3'd1, 1'b1, 1'b0, 1'b1);
    vt[11] = mk(32'h4000D093, 32'h12C, 4'd7,  5'd1,  5'd1, 5'd0, 32'h00000400, 3'd5, 1'b1, 1'b1, 1'b0);

    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 32'd0;
    in_pc     = 32'd0;
    out_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_in_ready",  64'(in_ready),     64'd0);
    chk("rst_out_valid", 64'(out_valid),    64'd0);
    chk("rst_count",     64'(count),        64'd0);
    chk("rst_out_pc",    64'(out_pc),       64'd0);
    chk("rst_out_imm",   64'(out_imm),      64'd0);
    chk("rst_out_rd_we", 64'(out_rd_we),    64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready_before_edge", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("rel_in_ready_after_edge", 64'(in_ready), 64'd1);

    // Streaming with continuous pop: occupancy stays 1 across pointer wraps
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      send(i);
      chk("stream_count", 64'(count), 64'd1);
    end
    drain();

    // Back-pressure: A, B fill the queue, C is held off
    out_ready = 1'b0;
    send(0);
    send(1);
    chk("full_count", 64'(count), 64'd2);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1;
    in_instr = vt[8].instr;
    in_pc    = vt[8].pc;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_count", 64'(count), 64'd2);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(8);
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    // Flush of a full queue with a same-cycle input
    out_ready = 1'b0;
    send(4);
    send(5);
    in_valid = 1'b1;
    in_instr = vt[3].instr;
    in_pc    = vt[3].pc;
    flush    = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_flush_count", 64'(count), 64'd0);

    // Asynchronous reset with two entries queued
    out_ready = 1'b0;
    send(6);
    send(9);
    chk("pre_rst_count", 64'(count), 64'd2);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_count", 64'(count), 64'd0);
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    chk("async_rst_in_ready", 64'(in_ready), 64'd0);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rerel_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    send(10);
    send(11);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
